moving_average_n: RTL
=====================

MOVING_AVERAGE_N -- requirements
Module: moving_average_n

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning sample and output width in bits (unsigned).
REQ-002 The block SHALL have parameter LOG2_DEPTH, default 3, meaning log2 of the window length; DEPTH = 2**LOG2_DEPTH, legal range 1..6.
REQ-003 The block SHALL have port CLOCK_50  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 The block SHALL have port clear  input  1  meaning synchronous flush of window contents, active-high.
REQ-006 The block SHALL have port bypass  input  1  meaning output raw sample instead of average when high.
REQ-007 The block SHALL have port in_valid  input  1  meaning in_data carries a new sample this cycle.
REQ-008 The block SHALL have port in_data  input  DATA_W  meaning sample value.
REQ-009 The block SHALL have port out_valid  output  1  meaning single-cycle pulse; out_data/out_sum updated.
REQ-010 The block SHALL have port out_data  output  DATA_W  meaning average (sum >> LOG2_DEPTH) or raw sample in bypass.
REQ-011 The block SHALL have port out_sum  output  DATA_W+LOG2_DEPTH  meaning running sum of the samples in the window.
REQ-012 The block SHALL have port window_full  output  1  meaning DEPTH samples have been accepted since the last reset/clear.

Function
REQ-013 The block SHALL accept a sample on every cycle where in_valid=1 and clear=0; no backpressure exists.
REQ-014 The block SHALL hold samples in a DEPTH-entry circular buffer with a write pointer that wraps from DEPTH-1 to 0.
REQ-015 The block SHALL track a fill count 0..DEPTH, incremented per accepted sample and saturating at DEPTH.
REQ-016 The block SHALL implement states EMPTY (count=0), FILLING (0<count<DEPTH) and FULL (count=DEPTH); EMPTY->FILLING on first sample, FILLING->FULL on the DEPTH-th sample, any state->EMPTY on clear.
REQ-017 The block SHALL compute sum_next = sum + in_data - oldest, where oldest = buffer[wr_ptr] in FULL and 0 otherwise (stale buffer contents never used).
REQ-018 The sum register SHALL be DATA_W+LOG2_DEPTH bits wide and SHALL never overflow or wrap.
REQ-019 The block SHALL assert out_valid exactly one cycle after each accepted sample, with out_sum = sum_next and out_data = sum_next >> LOG2_DEPTH (truncating).
REQ-020 The block, with bypass=1 at acceptance, SHALL drive out_data = the accepted in_data while still updating buffer, count and out_sum normally.
REQ-021 During FILLING, out_data SHALL equal sum >> LOG2_DEPTH (missing samples count as zero), not a partial-count average.
REQ-022 The block SHALL set window_full in the same cycle out_valid pulses for the DEPTH-th sample, and SHALL hold it high until reset or clear.
REQ-023 When in_valid=0, the block SHALL hold out_data, out_sum and window_full, with out_valid=0.
REQ-024 The block, when clear=1, SHALL next cycle zero sum, count, wr_ptr, out_sum, out_data and window_full, with out_valid=0; buffer contents need not be zeroed.
REQ-025 The block, when clear and in_valid are both 1, SHALL let clear win and drop the sample.

Reset
REQ-026 The block, on reset_n=0, SHALL immediately, asynchronously, force state EMPTY, sum=0, count=0, wr_ptr=0, out_valid=0, out_data=0, out_sum=0 and window_full=0.
REQ-027 Deassertion of reset_n mid-stream SHALL resume in EMPTY; the next accepted sample is treated as the first.

Verification (DATA_W=8, LOG2_DEPTH=2 unless noted)
REQ-028 Fill: samples 4,8,12,16 -> out_sum 4,12,24,40; out_data 1,3,6,10; window_full rises with the 4th out_valid.
REQ-029 Slide/wrap: after fill, samples 20,24 -> out_sum 56,72; out_data 14,18.
REQ-030 Saturation width: eight samples of 255 -> out_sum 1020 steady, out_data 255, no wrap.
REQ-031 Clear: after fill, clear=1 with in_valid=1 (sample 99 dropped), then sample 8 -> out_sum 8, out_data 2, window_full=0.
REQ-032 Bypass and gaps: bypass=1, samples 100 and 60 separated by 3 idle cycles -> out_data 100 then 60, out_sum 100 then 160, out_valid exactly two pulses.
REQ-033 Reset mid-stream, parameter sweep: pulse reset_n low after 2 samples, then rerun REQ-028; repeat with LOG2_DEPTH=1 and 6, DATA_W=12, checking all outputs against a reference model.

Source files
------------

// File: rtl/moving_average_n.sv
// Moving average over the last 2**LOG2_DEPTH accepted samples.
// The running sum is updated incrementally. out_data is the sum shifted right, or the raw sample when bypass is high.
module moving_average_n #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         bypass,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [DATA_W+LOG2_DEPTH-1:0] out_sum,
    output logic                         window_full,
    output logic [1:0]                   state_dbg
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1_C   = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE = LOG2_DEPTH'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic                    full_q, full_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    accept;
    logic [SUM_W-1:0]        oldest;
    logic [SUM_W-1:0]        sum_next;

    assign accept = in_valid & ~clear;

    // Only a full window holds a real sample at wr_ptr; before that, the slot may be stale.
    assign oldest   = (state_q == FULL) ? SUM_W'(mem_q[wr_ptr_q]) : '0;
    assign sum_next = sum_q + SUM_W'(in_data) - oldest;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        sum_d       = sum_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        full_d      = full_q;
        if (clear) begin
            state_d    = EMPTY;
            count_d    = '0;
            wr_ptr_d   = '0;
            sum_d      = '0;
            out_data_d = '0;
            full_d     = 1'b0;
        end else if (in_valid) begin
            sum_d       = sum_next;
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            out_valid_d = 1'b1;
            out_data_d  = bypass ? in_data : sum_next[SUM_W-1:LOG2_DEPTH];
            if (count_q != DEPTH_C) begin
                count_d = count_q + CNT_ONE;
            end
            case (state_q)
                EMPTY:   state_d = FILLING;
                FILLING: if (count_q == DEPTH_M1_C) state_d = FULL;
                FULL:    state_d = FULL;
                default: state_d = EMPTY;
            endcase
            full_d = (state_d == FULL);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            full_q      <= full_d;
        end
    end

    // Sample storage needs no reset; it is never read before being written.
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sum     = sum_q;
    assign window_full = full_q;
    assign state_dbg   = state_q;
endmodule
